// File: rtl/cgra_pkg.sv
// Shared constants for the CGRA run sequencer, Inst_Mem and the PE/PEIO tiles.
// Defaults here must agree with the instruction memory and tile builds.
package cgra_pkg;

    localparam int DEF_INST_AWIDTH  = 10;
    localparam int DEF_ITER_WIDTH   = 16;
    localparam int DEF_DRAIN_CYCLES = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } run_state_e;

endpackage

// File: rtl/cgra_loop_cnt.sv
// Instruction and iteration counters for one CGRA run, with terminal-count flags
// and a one-cycle look-ahead of the iteration boundary for the registered Inst_Clr.
module cgra_loop_cnt
    import cgra_pkg::*;
#(
    parameter int INST_AWIDTH = DEF_INST_AWIDTH,
    parameter int ITER_WIDTH  = DEF_ITER_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Resetn,
    input  logic                  load,
    input  logic                  step,
    input  logic [INST_AWIDTH:0]  inst_num,
    input  logic [ITER_WIDTH-1:0] iter_num,
    output logic [ITER_WIDTH-1:0] iter_cnt,
    output logic                  inst_last,
    output logic                  iter_last,
    output logic                  bound_next
);

    localparam logic [INST_AWIDTH:0] INST_ONE = (INST_AWIDTH + 1)'(1);
    localparam logic [ITER_WIDTH:0]  ITER_ONE = (ITER_WIDTH + 1)'(1);

    logic [INST_AWIDTH:0]  inst_num_q;
    logic [INST_AWIDTH:0]  inst_cnt_q;
    logic [INST_AWIDTH:0]  inst_cnt_d;
    logic [ITER_WIDTH-1:0] iter_num_q;
    logic [ITER_WIDTH-1:0] iter_cnt_q;
    logic [ITER_WIDTH-1:0] iter_cnt_d;

    // One extra bit on the iteration compare so Iter_Num = max does not wrap.
    always_comb begin
        inst_last = (inst_cnt_q == (inst_num_q - INST_ONE));
        iter_last = (({1'b0, iter_cnt_q} + ITER_ONE) >= {1'b0, iter_num_q});

        inst_cnt_d = inst_cnt_q;
        iter_cnt_d = iter_cnt_q;
        if (load) begin
            inst_cnt_d = '0;
            iter_cnt_d = '0;
        end else if (step) begin
            if (inst_last) begin
                inst_cnt_d = '0;
                if (!iter_last) begin
                    iter_cnt_d = iter_cnt_q + ITER_WIDTH'(1);
                end
            end else begin
                inst_cnt_d = inst_cnt_q + INST_ONE;
            end
        end

        bound_next = (inst_cnt_d == (inst_num_q - INST_ONE)) &&
                     (({1'b0, iter_cnt_d} + ITER_ONE) < {1'b0, iter_num_q});
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            inst_num_q <= '0;
            iter_num_q <= '0;
            inst_cnt_q <= '0;
            iter_cnt_q <= '0;
        end else begin
            inst_cnt_q <= inst_cnt_d;
            iter_cnt_q <= iter_cnt_d;
            if (load) begin
                inst_num_q <= inst_num;
                iter_num_q <= iter_num;
            end
        end
    end

    assign iter_cnt = iter_cnt_q;

endmodule

// File: rtl/cgra_run_ctrl.sv
// Run sequencer for the 4x4 CGRA: gates CGRA_Ena for Inst_Num*Iter_Num cycles,
// clears PCs between iterations and holds IO-buffer ownership through the drain.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for Start; host owns IO buffers
// ST_CLR   | one-cycle PC clear before the first iteration
// ST_RUN   | array enabled; PCs cleared on each non-final iteration boundary
// ST_DRAIN | array stopped, pipeline stores still landing in IO buffers
// ST_DONE  | one-cycle Done pulse, buffers handed back to host
module cgra_run_ctrl
    import cgra_pkg::*;
#(
    parameter int INST_AWIDTH  = DEF_INST_AWIDTH,
    parameter int ITER_WIDTH   = DEF_ITER_WIDTH,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic                  Clk,
    input  logic                  Resetn,
    input  logic                  Start,
    input  logic                  Abort,
    input  logic [INST_AWIDTH:0]  Inst_Num,
    input  logic [ITER_WIDTH-1:0] Iter_Num,
    output logic                  CGRA_Ena,
    output logic                  Inst_Clr,
    output logic                  Buf_Own,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Aborted,
    output logic [ITER_WIDTH-1:0] Iter_Cnt
);

    localparam int DRAIN_CW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_CW-1:0] DRAIN_LOAD = DRAIN_CW'(DRAIN_CYCLES - 1);

    run_state_e state_q;
    run_state_e state_d;

    logic                cnt_load;
    logic                cnt_step;
    logic                inst_last;
    logic                iter_last;
    logic                bound_next;
    logic [DRAIN_CW-1:0] drain_q;
    logic [DRAIN_CW-1:0] drain_d;

    logic ena_d;
    logic clr_d;
    logic own_d;
    logic busy_d;
    logic done_d;
    logic aborted_d;

    cgra_loop_cnt #(
        .INST_AWIDTH (INST_AWIDTH),
        .ITER_WIDTH  (ITER_WIDTH)
    ) u_loop_cnt (
        .Clk        (Clk),
        .Resetn     (Resetn),
        .load       (cnt_load),
        .step       (cnt_step),
        .inst_num   (Inst_Num),
        .iter_num   (Iter_Num),
        .iter_cnt   (Iter_Cnt),
        .inst_last  (inst_last),
        .iter_last  (iter_last),
        .bound_next (bound_next)
    );

    always_comb begin
        state_d   = state_q;
        cnt_load  = 1'b0;
        cnt_step  = 1'b0;
        drain_d   = drain_q;
        aborted_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start && !Abort) begin
                    cnt_load = 1'b1;
                    if ((Inst_Num == '0) || (Iter_Num == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CLR;
                    end
                end
            end
            ST_CLR: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_step = 1'b1;
                if (inst_last && iter_last) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - DRAIN_CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Done is already on the wire in ST_DONE, so an abort there is silent.
        if (Abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            cnt_step  = 1'b0;
            aborted_d = (state_q != ST_DONE);
        end

        // Outputs are registered, so they are decoded from the next state.
        ena_d  = (state_d == ST_RUN);
        own_d  = (state_d == ST_CLR) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        clr_d  = (state_d == ST_CLR) || ((state_d == ST_RUN) && bound_next);
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= ST_IDLE;
            drain_q  <= '0;
            CGRA_Ena <= 1'b0;
            Inst_Clr <= 1'b0;
            Buf_Own  <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Aborted  <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            CGRA_Ena <= ena_d;
            Inst_Clr <= clr_d;
            Buf_Own  <= own_d;
            Busy     <= busy_d;
            Done     <= done_d;
            Aborted  <= aborted_d;
        end
    end

endmodule

// File: doc/cgra_run_ctrl.md
Name: cgra_run_ctrl

Overview:
- Run sequencer for the 4x4 CGRA array of PE/PEIO tiles.
- Receives a host Start command with instruction count and iteration count, then drives the array-wide CGRA_Ena for exactly the programmed number of instruction cycles per iteration.
- Clears the instruction pointers between iterations and holds IO-buffer ownership through the pipeline drain.
- Reports Done/Busy back to the host-side wrapper. It sits between the host register interface and every tile's Inst_Mem and IO buffer.

Parameters:
- INST_AWIDTH, 10, instruction memory address width; max program length 2^INST_AWIDTH.
- ITER_WIDTH, 16, width of the iteration count and counter.
- DRAIN_CYCLES, 6, cycles after the last enabled instruction until the final PE_Store/IOBuf_Push lands (2 inst regs + mem read + mem out reg + PE_Store reg + 1 margin).

Ports:
- Clk  input  1  system clock, all logic on rising edge
- Resetn  input  1  asynchronous active-low reset
- Start  input  1  host run request, sampled only in IDLE
- Abort  input  1  host abort, highest priority
- Inst_Num  input  INST_AWIDTH+1  instructions per iteration, 0..2^INST_AWIDTH
- Iter_Num  input  ITER_WIDTH  iterations per run
- CGRA_Ena  output  1  broadcast enable to all tile Inst_Mem program counters
- Inst_Clr  output  1  broadcast synchronous PC clear; wins over increment in Inst_Mem
- Buf_Own  output  1  1 = CGRA owns IO buffers, 0 = host owns
- Busy  output  1  high in every state except IDLE
- Done  output  1  one-cycle completion pulse
- Aborted  output  1  one-cycle pulse when an abort takes effect
- Iter_Cnt  output  ITER_WIDTH  index of the current iteration, 0-based

Behaviour:
- Clock and reset: one clock (Clk). Reset is asynchronous and active-low (Resetn). All state and outputs are registered (Moore).
- Reset values: state IDLE; all outputs 0; internal counters 0; latched Inst_Num/Iter_Num 0.
- States: IDLE, CLR, RUN, DRAIN, DONE.
- IDLE:
  - Start=1 latches Inst_Num and Iter_Num.
  - If either latched value is 0, next state is DONE (no enable cycles). Otherwise next state is CLR.
  - Start outside IDLE is ignored, with no queuing.
- CLR (1 cycle): Inst_Clr=1, Buf_Own=1, CGRA_Ena=0, Iter_Cnt=0; go to RUN.
- RUN:
  - CGRA_Ena=1 and Buf_Own=1. The instruction counter increments each cycle.
  - On the cycle where the counter equals Inst_Num-1:
    - If Iter_Cnt+1 < Iter_Num: Inst_Clr=1 on that same cycle, counter returns to 0, Iter_Cnt increments, and the state stays RUN. The iteration boundary has no bubble.
    - Otherwise: go to DRAIN, counter returns to 0.
  - Total CGRA_Ena-high cycles per run = Inst_Num * Iter_Num exactly.
- Inst_Num = 2^INST_AWIDTH: the counter needs INST_AWIDTH+1 bits. The compare must not wrap early.
- DRAIN: CGRA_Ena=0, Buf_Own=1. Count DRAIN_CYCLES cycles, then go to DONE.
- DONE (1 cycle): Done=1, Buf_Own=0, Busy=1; go to IDLE. Iter_Cnt holds its final value until the next Start.
- Abort:
  - Any non-IDLE state goes to IDLE on the next edge. CGRA_Ena, Inst_Clr, Buf_Own and Busy drop at that edge.
  - Aborted=1 for one cycle; Done is not asserted.
  - Abort and Start together in IDLE: stay IDLE with no Aborted pulse. Abort in IDLE has no effect.
- Abort in DONE: Done still pulses this cycle (already registered), then the state goes to IDLE with no Aborted pulse.
- Input stability: Inst_Num/Iter_Num changes after latching have no effect on the current run.
- Reset mid-run: everything returns to reset values immediately (asynchronous); no Done.

Decomposition:
- Shared package cgra_pkg:
  - state encoding constants (IDLE=0, CLR=1, RUN=2, DRAIN=3, DONE=4, 3 bits);
  - DRAIN_CYCLES default;
  - INST_AWIDTH, ITER_WIDTH defaults, shared with Inst_Mem and the PE/PEIO tiles.
- One natural sub-module: cgra_loop_cnt, holding the instruction counter and iteration counter with terminal-count flags. The FSM stays in the top module.

Test Plan:
- Reset then Start with Inst_Num=4, Iter_Num=1 -> Inst_Clr pulse 1 cycle after Start; CGRA_Ena high exactly 4 cycles; Buf_Own high 1+4+6 cycles; Done pulses on the 12th cycle after Start; Busy low afterwards.
- Inst_Num=3, Iter_Num=3 -> CGRA_Ena high 9 consecutive cycles; Inst_Clr pulses in CLR and at enable cycles 3 and 6; Iter_Cnt steps 0,1,2; one Done pulse.
- Inst_Num=0 or Iter_Num=0 -> no CGRA_Ena, no Inst_Clr; Done 1 cycle after Start; Buf_Own stays 0.
- Abort during RUN at enable cycle 2 of Inst_Num=8 -> CGRA_Ena low at the next edge; Aborted pulse 1 cycle; no Done; a new Start then completes normally.
- Start re-asserted during RUN/DRAIN, and Abort together with Start in IDLE -> ignored; enable count unchanged; no Aborted pulse.
- Inst_Num=1024, Iter_Num=2 -> exactly 2048 CGRA_Ena cycles with no early wrap; asynchronous Resetn deassertion mid-run clears all outputs immediately.
